// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate fronting a word-organised on-chip SRAM.
// Supports programmable data-phase wait states and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int                     HADDR_WIDTH = 32,
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     MEM_DEPTH   = 1024,
    parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = 32'h4003_0000,
    parameter int                     WAIT_STATES = 0
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    hsel,
    input  logic [HADDR_WIDTH-1:0]  haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic                    hprot,
    input  logic                    hmastlock,
    input  logic                    hready,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata
);

    localparam int BE = DATA_WIDTH / 8;
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [HADDR_WIDTH-1:0] MEM_BYTES =
        HADDR_WIDTH'(MEM_DEPTH * BE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e                  state_q;
    logic [2:0]              cnt_q;
    logic [IW-1:0]           idx_q;
    logic [BE-1:0]           mask_q;
    logic                    write_q;
    logic                    hreadyout_q;
    logic                    hresp_q;
    logic [DATA_WIDTH-1:0]   hrdata_q;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic                    accept;
    logic                    acc_err;
    logic                    in_range;
    logic                    misalign;
    logic [HADDR_WIDTH-1:0]  rel;
    logic [IW-1:0]           acc_idx;
    logic [IW-1:0]           rd_idx;
    logic [BE-1:0]           acc_mask;
    logic [BE-1:0]           wr_be;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    unused_ok;

    assign unused_ok = ^{hburst, hprot, hmastlock};

    assign accept   = hsel & hready & htrans[1];
    assign rel      = haddr - BASE_ADDR;
    assign in_range = (haddr >= BASE_ADDR) && (rel < MEM_BYTES);
    assign acc_idx  = rel[IW+1:2];
    assign misalign = ((hsize == 3'd1) & haddr[0]) |
                      ((hsize == 3'd2) & (|haddr[1:0]));
    assign acc_err  = !in_range || misalign || (hsize > 3'd2);

    always_comb begin
        acc_mask = '0;
        unique case (hsize)
            3'd0:    acc_mask = BE'(1) << haddr[1:0];
            3'd1:    acc_mask = BE'(3) << haddr[1:0];
            default: acc_mask = '1;
        endcase
    end

    assign wr_en  = (state_q == S_DATA) & write_q;
    assign wr_be  = mask_q & hwstrb & {BE{wr_en}};
    assign rd_idx = (state_q == S_WAIT) ? idx_q : acc_idx;

    // A W=0 read accepted while a write to the same word closes sees the new bytes.
    always_comb begin
        rd_word = mem_q[rd_idx];
        for (int i = 0; i < BE; i++) begin
            if (wr_be[i] && (idx_q == rd_idx)) begin
                rd_word[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        for (int i = 0; i < BE; i++) begin
            if (wr_be[i]) begin
                mem_q[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            mask_q      <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            unique case (state_q)
                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= S_DATA;
                        if (!write_q) begin
                            hrdata_q <= rd_word;
                        end
                    end else begin
                        cnt_q       <= cnt_q - 3'd1;
                        hreadyout_q <= 1'b0;
                    end
                end
                S_ERR1: begin
                    state_q <= S_ERR2;
                    hresp_q <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        idx_q   <= acc_idx;
                        mask_q  <= acc_mask;
                        write_q <= hwrite;
                        if (acc_err) begin
                            state_q     <= S_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state_q     <= S_WAIT;
                            cnt_q       <= 3'(WAIT_STATES - 1);
                            hreadyout_q <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            if (!hwrite) begin
                                hrdata_q <= rd_word;
                            end
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with no wait states, one with three.
// Transfers are pipelined by a small bus driver and checked against a byte-level model.
module tb_ahb_sram_slave;

    localparam logic [31:0] BASE  = 32'h4003_0000;
    localparam int          DEPTH = 1024;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        int          waits;
        logic        err1;
    } res_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b1;
    int          cur = 0;
    logic        sel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        sel0, sel3;
    logic        ro0, ro3, rs0, rs3;
    logic [31:0] rd0, rd3;
    logic        o_rdy, o_resp;
    logic [31:0] o_rdata;

    int checks = 0;
    int fails  = 0;

    logic [31:0] mdl [2][DEPTH];
    txn_t tq[$];
    res_t rq[$];
    res_t eq[$];

    always #5 hclk = ~hclk;

    assign sel0    = sel & (cur == 0);
    assign sel3    = sel & (cur == 1);
    assign o_rdy   = (cur == 1) ? ro3 : ro0;
    assign o_resp  = (cur == 1) ? rs3 : rs0;
    assign o_rdata = (cur == 1) ? rd3 : rd0;

    ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(sel0), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(3'd0),
        .hprot(1'b0), .hmastlock(1'b0), .hready(ro0), .hwdata(hwdata),
        .hwstrb(hwstrb), .hreadyout(ro0), .hresp(rs0), .hrdata(rd0)
    );

    ahb_sram_slave #(.WAIT_STATES(3)) u_dut3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(sel3), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(3'd0),
        .hprot(1'b0), .hmastlock(1'b0), .hready(ro3), .hwdata(hwdata),
        .hwstrb(hwstrb), .hreadyout(ro3), .hresp(rs3), .hrdata(rd3)
    );

    // Byte-addressed reference: a transfer touches bytes [off, off+2^size).
    function automatic res_t model_step(input int d, input txn_t t);
        res_t   e;
        longint a   = longint'(t.addr);
        longint lo  = longint'(BASE);
        int     nb  = 1 << t.size;
        int     off = int'(t.addr[1:0]);
        int     idx;
        logic   err;
        err = (a < lo) || (a >= lo + 4 * DEPTH) ||
              (t.size > 3'd2) || ((a % nb) != 0);
        e.rdata = '0;
        e.resp  = err;
        e.err1  = err;
        e.waits = err ? 1 : ((d == 0) ? 0 : 3);
        if (!err) begin
            idx = int'((a - lo) / 4);
            if (t.write) begin
                for (int k = 0; k < 4; k++) begin
                    if (k >= off && k < off + nb && t.wstrb[k]) begin
                        mdl[d][idx][8*k +: 8] = t.wdata[8*k +: 8];
                    end
                end
            end else begin
                e.rdata = mdl[d][idx];
            end
        end
        return e;
    endfunction

    task automatic push(input logic [31:0] addr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] wd,
                        input logic [3:0] st);
        txn_t t;
        t.addr = addr; t.write = wr; t.size = sz;
        t.wdata = wd; t.wstrb = st;
        tq.push_back(t);
    endtask

    task automatic run_seq(input int d);
        int   a, dp, w, cyc, n;
        logic e1, rdy;
        res_t r;
        n = tq.size(); a = 0; dp = -1; w = 0; cyc = 0; e1 = 1'b0;
        rq.delete();
        eq.delete();
        foreach (tq[i]) eq.push_back(model_step(d, tq[i]));
        cur = d;
        while ((a < n || dp >= 0) && cyc < 20 * (n + 1)) begin
            rdy = o_rdy;
            if (dp >= 0) begin
                if (rdy) begin
                    r.rdata = o_rdata; r.resp = o_resp;
                    r.waits = w; r.err1 = e1;
                    rq.push_back(r);
                end else begin
                    w++;
                    if (o_resp) e1 = 1'b1;
                end
            end
            if (a < n) begin
                sel = 1'b1; haddr = tq[a].addr;
                htrans = (a == 0) ? 2'b10 : 2'b11;
                hwrite = tq[a].write; hsize = tq[a].size;
            end else begin
                sel = 1'b0; htrans = 2'b00;
            end
            if (dp >= 0) begin
                hwdata = tq[dp].wdata; hwstrb = tq[dp].wstrb;
            end else begin
                hwdata = '0; hwstrb = '0;
            end
            @(posedge hclk); #1;
            cyc++;
            if (rdy) begin
                if (a < n) begin dp = a; a++; end
                else dp = -1;
                w = 0; e1 = 1'b0;
            end
        end
        checks++;
        if (a < n || dp >= 0) begin
            fails++;
            $display("FAIL seq_timeout d%0d: got %0d done want %0d", d, rq.size(), n);
        end
        while (rq.size() < n) begin
            r.rdata = 'x; r.resp = 1'bx; r.waits = -1; r.err1 = 1'bx;
            rq.push_back(r);
        end
        sel = 1'b0; htrans = 2'b00; hwdata = '0; hwstrb = '0;
    endtask

    task automatic test_reset;
        #1 hresetn = 1'b0;
        #2;
        checks++;
        if ({ro0, rs0, rd0} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_d0: got rdy=%b resp=%b rdata=%h want 1 0 0", ro0, rs0, rd0);
        end
        checks++;
        if ({ro3, rs3, rd3} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_d3: got rdy=%b resp=%b rdata=%h want 1 0 0", ro3, rs3, rd3);
        end
        @(negedge hclk); @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk); #1;
    endtask

    task automatic test_init;
        for (int d = 0; d < 2; d++) begin
            tq.delete();
            for (int i = 0; i < 32; i++) push(BASE + 32'(4 * i), 1'b1, 3'd2, $urandom, 4'hF);
            run_seq(d);
            foreach (rq[i]) begin
                checks++;
                if (rq[i].resp !== 1'b0 || rq[i].waits != eq[i].waits) begin
                    fails++;
                    $display("FAIL init_d%0d #%0d: got resp=%b waits=%0d want 0 %0d",
                             d, i, rq[i].resp, rq[i].waits, eq[i].waits);
                end
            end
        end
    endtask

    task automatic test_word_rw;
        tq.delete();
        push(BASE + 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 4'hF);
        push(BASE + 32'h10, 1'b0, 3'd2, 32'h0, 4'h0);
        run_seq(0);
        checks++;
        if (rq[1].rdata !== 32'hDEAD_BEEF || rq[1].resp !== 1'b0) begin
            fails++;
            $display("FAIL word_rw: got %h resp=%b want deadbeef 0", rq[1].rdata, rq[1].resp);
        end
        checks++;
        if (rq[0].waits != 0 || rq[1].waits != 0) begin
            fails++;
            $display("FAIL word_rw_waits: got %0d %0d want 0 0", rq[0].waits, rq[1].waits);
        end
    endtask

    task automatic test_lanes;
        tq.delete();
        push(BASE + 32'h20, 1'b1, 3'd2, 32'h1122_3344, 4'hF);
        push(BASE + 32'h21, 1'b1, 3'd0, 32'h9999_AA99, 4'hF);
        push(BASE + 32'h22, 1'b1, 3'd1, 32'h5566_7777, 4'hF);
        push(BASE + 32'h20, 1'b0, 3'd2, 32'h0, 4'h0);
        run_seq(0);
        checks++;
        if (rq[3].rdata !== 32'h5566_AA44) begin
            fails++;
            $display("FAIL lanes: got %h want 5566aa44", rq[3].rdata);
        end
    endtask

    task automatic test_strobe;
        tq.delete();
        push(BASE + 32'h30, 1'b1, 3'd2, 32'h0, 4'hF);
        push(BASE + 32'h30, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'b0101);
        push(BASE + 32'h30, 1'b0, 3'd2, 32'h0, 4'h0);
        run_seq(0);
        checks++;
        if (rq[2].rdata !== 32'h00FF_00FF) begin
            fails++;
            $display("FAIL strobe: got %h want 00ff00ff", rq[2].rdata);
        end
    endtask

    task automatic test_wait_states;
        tq.delete();
        push(BASE + 32'h40, 1'b0, 3'd2, 32'h0, 4'h0);
        push(BASE + 32'h44, 1'b0, 3'd2, 32'h0, 4'h0);
        push(BASE + 32'h44, 1'b1, 3'd2, 32'hCAFE_F00D, 4'hF);
        push(BASE + 32'h44, 1'b0, 3'd2, 32'h0, 4'h0);
        run_seq(1);
        foreach (rq[i]) begin
            checks++;
            if (rq[i].waits != 3 || rq[i].resp !== 1'b0 || rq[i].err1 !== 1'b0) begin
                fails++;
                $display("FAIL wait_timing #%0d: got waits=%0d resp=%b want 3 0",
                         i, rq[i].waits, rq[i].resp);
            end
            checks++;
            if (rq[i].rdata !== eq[i].rdata) begin
                fails++;
                $display("FAIL wait_rdata #%0d: got %h want %h", i, rq[i].rdata, eq[i].rdata);
            end
        end
        checks++;
        if (rq[3].rdata !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL wait_raw: got %h want cafef00d", rq[3].rdata);
        end
    endtask

    task automatic test_errors;
        tq.delete();
        push(BASE + 32'h1000, 1'b1, 3'd2, 32'h0BAD_0BAD, 4'hF);
        push(BASE, 1'b0, 3'd2, 32'h0, 4'h0);
        push(BASE + 32'h1, 1'b0, 3'd1, 32'h0, 4'h0);
        push(BASE + 32'h8, 1'b1, 3'd3, 32'h0BAD_0BAD, 4'hF);
        push(BASE + 32'h8, 1'b0, 3'd2, 32'h0, 4'h0);
        push(BASE - 32'h4, 1'b0, 3'd2, 32'h0, 4'h0);
        for (int d = 0; d < 2; d++) begin
            run_seq(d);
            foreach (rq[i]) begin
                checks++;
                if (rq[i].resp !== eq[i].resp || rq[i].err1 !== eq[i].err1 ||
                    rq[i].waits != eq[i].waits || rq[i].rdata !== eq[i].rdata) begin
                    fails++;
                    $display("FAIL err_d%0d #%0d: got resp=%b e1=%b w=%0d %h want %b %b %0d %h",
                             d, i, rq[i].resp, rq[i].err1, rq[i].waits, rq[i].rdata,
                             eq[i].resp, eq[i].err1, eq[i].waits, eq[i].rdata);
                end
            end
        end
        checks++;
        if (eq[0].resp !== 1'b1 || rq[0].waits != 1 || rq[2].resp !== 1'b1) begin
            fails++;
            $display("FAIL err_shape: got resp=%b waits=%0d half=%b want 1 1 1",
                     rq[0].resp, rq[0].waits, rq[2].resp);
        end
    endtask

    task automatic test_idle;
        logic [1:0] tr [3];
        logic       sl [3];
        tr[0] = 2'b00; tr[1] = 2'b01; tr[2] = 2'b10;
        sl[0] = 1'b1;  sl[1] = 1'b1;  sl[2] = 1'b0;
        cur = 0;
        for (int i = 0; i < 3; i++) begin
            sel = sl[i]; htrans = tr[i]; haddr = BASE;
            hwrite = 1'b1; hsize = 3'd2;
            hwdata = 32'hFFFF_FFFF; hwstrb = 4'hF;
            @(posedge hclk); #1;
            checks++;
            if ({o_rdy, o_resp, o_rdata} !== {1'b1, 1'b0, 32'h0}) begin
                fails++;
                $display("FAIL idle #%0d: got rdy=%b resp=%b rdata=%h want 1 0 0",
                         i, o_rdy, o_resp, o_rdata);
            end
        end
        sel = 1'b0; htrans = 2'b00;
        tq.delete();
        push(BASE, 1'b0, 3'd2, 32'h0, 4'h0);
        run_seq(0);
        checks++;
        if (rq[0].rdata !== eq[0].rdata) begin
            fails++;
            $display("FAIL idle_nowrite: got %h want %h", rq[0].rdata, eq[0].rdata);
        end
    endtask

    task automatic test_random;
        int          r, sz, idx, off;
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            tq.delete();
            for (int i = 0; i < 60; i++) begin
                r   = $urandom_range(0, 99);
                sz  = $urandom_range(0, 9);
                sz  = (sz < 1) ? 3 : (sz < 4) ? 0 : (sz < 7) ? 1 : 2;
                idx = $urandom_range(0, 31);
                if ($urandom_range(0, 4) == 0) off = $urandom_range(0, 3);
                else if (sz == 0) off = $urandom_range(0, 3);
                else if (sz == 1) off = 2 * $urandom_range(0, 1);
                else off = 0;
                a = BASE + 32'(4 * idx + off);
                if (r < 4) a = BASE - 32'(4 + 4 * idx);
                else if (r < 8) a = BASE + 32'h1000 + 32'(4 * idx);
                push(a, 1'($urandom_range(0, 1)), 3'(sz), $urandom,
                     4'($urandom_range(0, 15)));
            end
            run_seq(d);
            foreach (rq[i]) begin
                checks++;
                if (rq[i].rdata !== eq[i].rdata) begin
                    fails++;
                    $display("FAIL rand_rdata d%0d #%0d: got %h want %h",
                             d, i, rq[i].rdata, eq[i].rdata);
                end
                checks++;
                if (rq[i].resp !== eq[i].resp || rq[i].err1 !== eq[i].err1 ||
                    rq[i].waits != eq[i].waits) begin
                    fails++;
                    $display("FAIL rand_resp d%0d #%0d: got %b/%b/%0d want %b/%b/%0d",
                             d, i, rq[i].resp, rq[i].err1, rq[i].waits,
                             eq[i].resp, eq[i].err1, eq[i].waits);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        cur = 1;
        sel = 1'b1; haddr = BASE + 32'h14; htrans = 2'b10;
        hwrite = 1'b1; hsize = 3'd2; hwstrb = 4'hF; hwdata = '0;
        @(posedge hclk); #1;
        sel = 1'b0; htrans = 2'b00; hwdata = ~mdl[1][5];
        checks++;
        if (o_rdy !== 1'b0) begin
            fails++;
            $display("FAIL mid_wait: got rdy=%b want 0", o_rdy);
        end
        @(posedge hclk); #3;
        hresetn = 1'b0;
        #1;
        checks++;
        if ({ro3, rs3, rd3} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL mid_reset: got rdy=%b resp=%b rdata=%h want 1 0 0", ro3, rs3, rd3);
        end
        @(negedge hclk); @(negedge hclk);
        hresetn = 1'b1; hwdata = '0; hwstrb = '0;
        @(posedge hclk); #1;
        tq.delete();
        push(BASE + 32'h14, 1'b0, 3'd2, 32'h0, 4'h0);
        run_seq(1);
        checks++;
        if (rq[0].rdata !== eq[0].rdata || rq[0].waits != 3) begin
            fails++;
            $display("FAIL mid_dropped: got %h w=%0d want %h 3", rq[0].rdata, rq[0].waits, eq[0].rdata);
        end
        run_seq(0);
        checks++;
        if (rq[0].rdata !== eq[0].rdata) begin
            fails++;
            $display("FAIL mid_retain: got %h want %h", rq[0].rdata, eq[0].rdata);
        end
    endtask

    initial begin
        sel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hwdata = '0; hwstrb = '0;
        test_reset();
        test_init();
        test_word_rw();
        test_lanes();
        test_strobe();
        test_wait_states();
        test_errors();
        test_idle();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
